// File: rtl/sal_bank_ctrl.sv
// Per-bank DDR2 command sequencer: opens/closes one bank's row and
// issues ACT/RD/WR/PRE under the bank's timing counters.
module sal_bank_ctrl #(
    parameter int BANK_ID    = 0,
    parameter int BA_WIDTH   = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int COL_WIDTH  = 10,
    parameter int T_RCD      = 4,
    parameter int T_RP       = 4,
    parameter int T_RAS      = 12,
    parameter int T_RTP      = 2,
    parameter int T_WTP      = 9,
    parameter int T_CCD      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_row,
    input  logic [COL_WIDTH-1:0]  req_col,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_type,
    output logic [BA_WIDTH-1:0]   cmd_ba,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  ref_req,
    output logic                  ref_ack,
    output logic                  bank_open,
    output logic [ADDR_WIDTH-1:0] open_row
);

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_e;

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } state_e;

    localparam logic [5:0] RCD_L = 6'(T_RCD - 1);
    localparam logic [5:0] RP_L  = 6'(T_RP - 1);
    localparam logic [5:0] RAS_L = 6'(T_RAS - 1);
    localparam logic [5:0] RTP_L = 6'(T_RTP - 1);
    localparam logic [5:0] WTP_L = 6'(T_WTP - 1);
    localparam logic [5:0] CCD_L = 6'(T_CCD - 1);

    function automatic logic [5:0] dec(input logic [5:0] v);
        return (v == 6'd0) ? 6'd0 : v - 6'd1;
    endfunction

    function automatic logic [5:0] max6(input logic [5:0] a,
                                        input logic [5:0] b);
        return (a > b) ? a : b;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  pv_q, pv_d;
    logic                  pwr_q, pwr_d;
    logic [ADDR_WIDTH-1:0] prow_q, prow_d;
    logic [COL_WIDTH-1:0]  pcol_q, pcol_d;
    logic [5:0]            rcd_q, rcd_d;
    logic [5:0]            rp_q, rp_d;
    logic [5:0]            ras_q, ras_d;
    logic [5:0]            pre_q, pre_d;
    logic [5:0]            ccd_q, ccd_d;
    logic                  hold_q, hold_d;
    cmd_e                  htype_q, htype_d;

    logic hit_ok, pre_ok, act_ok, fire;
    cmd_e cmd_t;

    assign hit_ok = (state_q == ST_OPEN) && pv_q && (prow_q == row_q)
                    && (rcd_q == 6'd0) && (ccd_q == 6'd0);
    assign pre_ok = (state_q == ST_OPEN)
                    && (ref_req || (pv_q && (prow_q != row_q)))
                    && (ras_q == 6'd0) && (pre_q == 6'd0);
    assign act_ok = (state_q == ST_CLOSED) && pv_q && !ref_req
                    && (rp_q == 6'd0);

    // An offered command is frozen until taken; only refresh may pull an ACT.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_t     = CMD_ACT;
        if (hold_q && !(htype_q == CMD_ACT && ref_req)) begin
            cmd_valid = 1'b1;
            cmd_t     = htype_q;
        end else if (hit_ok) begin
            cmd_valid = 1'b1;
            cmd_t     = pwr_q ? CMD_WR : CMD_RD;
        end else if (pre_ok) begin
            cmd_valid = 1'b1;
            cmd_t     = CMD_PRE;
        end else if (act_ok) begin
            cmd_valid = 1'b1;
            cmd_t     = CMD_ACT;
        end
    end

    always_comb begin
        cmd_addr = '0;
        if (cmd_valid) begin
            unique case (cmd_t)
                CMD_ACT: cmd_addr = prow_q;
                CMD_RD:  cmd_addr = ADDR_WIDTH'(pcol_q);
                CMD_WR:  cmd_addr = ADDR_WIDTH'(pcol_q);
                CMD_PRE: cmd_addr = '0;
            endcase
        end
    end

    assign fire      = cmd_valid && cmd_ready;
    assign cmd_type  = cmd_t;
    assign cmd_ba    = BA_WIDTH'(BANK_ID);
    assign req_ready = !pv_q && !ref_req;
    assign ref_ack   = (state_q == ST_CLOSED) && (rp_q == 6'd0);
    assign bank_open = (state_q == ST_OPEN);
    assign open_row  = row_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pv_d    = pv_q;
        pwr_d   = pwr_q;
        prow_d  = prow_q;
        pcol_d  = pcol_q;
        rcd_d   = dec(rcd_q);
        rp_d    = dec(rp_q);
        ras_d   = dec(ras_q);
        pre_d   = dec(pre_q);
        ccd_d   = dec(ccd_q);
        hold_d  = cmd_valid && !cmd_ready;
        htype_d = cmd_t;
        if (fire) begin
            unique case (cmd_t)
                CMD_ACT: begin
                    state_d = ST_OPEN;
                    row_d   = prow_q;
                    rcd_d   = RCD_L;
                    ras_d   = RAS_L;
                end
                CMD_RD: begin
                    pv_d  = 1'b0;
                    ccd_d = CCD_L;
                    pre_d = max6(dec(pre_q), RTP_L);
                end
                CMD_WR: begin
                    pv_d  = 1'b0;
                    ccd_d = CCD_L;
                    pre_d = max6(dec(pre_q), WTP_L);
                end
                CMD_PRE: begin
                    state_d = ST_CLOSED;
                    rp_d    = RP_L;
                end
            endcase
        end
        if (req_valid && req_ready) begin
            pv_d   = 1'b1;
            pwr_d  = req_wr;
            prow_d = req_row;
            pcol_d = req_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLOSED;
            row_q   <= '0;
            pv_q    <= 1'b0;
            pwr_q   <= 1'b0;
            prow_q  <= '0;
            pcol_q  <= '0;
            rcd_q   <= '0;
            rp_q    <= '0;
            ras_q   <= '0;
            pre_q   <= '0;
            ccd_q   <= '0;
            hold_q  <= 1'b0;
            htype_q <= CMD_ACT;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pv_q    <= pv_d;
            pwr_q   <= pwr_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
            rcd_q   <= rcd_d;
            rp_q    <= rp_d;
            ras_q   <= ras_d;
            pre_q   <= pre_d;
            ccd_q   <= ccd_d;
            hold_q  <= hold_d;
            htype_q <= htype_d;
        end
    end

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: timestamp-based reference model checked
// every cycle, plus directed timing scenarios and a random phase.
module tb_sal_bank_ctrl;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RAS = 12;
    localparam int T_RTP = 2;
    localparam int T_WTP = 9;
    localparam int T_CCD = 2;
    localparam int NLOG  = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_type;
    logic [2:0]  cmd_ba;
    logic [13:0] cmd_addr;
    logic        ref_req, ref_ack, bank_open;
    logic [13:0] open_row;

    sal_bank_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .bank_open(bank_open), .open_row(open_row)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int now = 0;

    // model: times of last commands, open row, pending request, held offer
    int          t_act, t_pre, t_rd, t_wr, t_col;
    bit          m_open, pv, pwr, hv;
    logic [13:0] m_row, prow;
    logic [9:0]  pcol;
    logic [1:0]  ht;
    bit          e_v, e_rr, e_ack;
    logic [1:0]  e_t;
    logic [13:0] e_a;

    logic        d_v [NLOG];
    logic        d_f [NLOG];
    logic [1:0]  d_t [NLOG];
    logic [13:0] d_a [NLOG];
    logic        d_rr [NLOG];
    logic        d_ack [NLOG];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dc(input int i);
        return {d_f[i], d_t[i]};
    endfunction

    task automatic model_reset();
        t_act = -1000; t_pre = -1000; t_rd = -1000;
        t_wr = -1000; t_col = -1000;
        m_open = 0; pv = 0; pwr = 0; hv = 0; ht = 0;
        m_row = '0; prow = '0; pcol = '0;
    endtask

    task automatic eval();
        bit hit, pre, act;
        hit = m_open && pv && prow == m_row && now >= t_act + T_RCD
              && now >= t_col + T_CCD;
        pre = m_open && (ref_req || (pv && prow != m_row))
              && now >= t_act + T_RAS && now >= t_rd + T_RTP
              && now >= t_wr + T_WTP;
        act = !m_open && pv && !ref_req && now >= t_pre + T_RP;
        e_v = 1; e_t = 0;
        if (hv && !(ht == 2'd0 && ref_req)) e_t = ht;
        else if (hit) e_t = pwr ? 2'd2 : 2'd1;
        else if (pre) e_t = 2'd3;
        else if (act) e_t = 2'd0;
        else e_v = 0;
        case (e_t)
            2'd0: e_a = prow;
            2'd3: e_a = '0;
            default: e_a = {4'd0, pcol};
        endcase
        if (!e_v) e_a = '0;
        e_rr  = !pv && !ref_req;
        e_ack = !m_open && now >= t_pre + T_RP;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval();
        if (now < NLOG) begin
            d_v[now] = cmd_valid; d_f[now] = cmd_valid && cmd_ready;
            d_t[now] = cmd_type;  d_a[now] = cmd_addr;
            d_rr[now] = req_ready; d_ack[now] = ref_ack;
        end
        chk("cmd_valid", 32'(cmd_valid), 32'(e_v));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("ref_ack", 32'(ref_ack), 32'(e_ack));
        chk("bank_open", 32'(bank_open), 32'(m_open));
        chk("open_row", 32'(open_row), 32'(m_row));
        chk("cmd_ba", 32'(cmd_ba), 32'd0);
        if (e_v) begin
            chk("cmd_type", 32'(cmd_type), 32'(e_t));
            chk("cmd_addr", 32'(cmd_addr), 32'(e_a));
        end
        @(posedge clk);
        if (e_v && cmd_ready) begin
            case (e_t)
                2'd0: begin m_open = 1; m_row = prow; t_act = now; end
                2'd1: begin t_rd = now; t_col = now; pv = 0; end
                2'd2: begin t_wr = now; t_col = now; pv = 0; end
                default: begin m_open = 0; t_pre = now; end
            endcase
        end
        hv = e_v && !cmd_ready;
        ht = e_t;
        if (req_valid && e_rr) begin
            pv = 1; pwr = req_wr; prow = req_row; pcol = req_col;
        end
        now++;
        #1;
    endtask

    task automatic drive(input bit v, input bit wr, input logic [13:0] row,
                         input logic [9:0] col, input bit rf, input bit rdy);
        req_valid = v; req_wr = wr; req_row = row; req_col = col;
        ref_req = rf; cmd_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_type", 32'(cmd_type), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_bank_open", 32'(bank_open), 32'd0);
        chk("rst_open_row", 32'(open_row), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'(!ref_req));
        chk("rst_ref_ack", 32'(ref_ack), 32'd1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        int nact;
        bit rf;
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 1);
        #2;
        chk("por_cmd_ba", 32'(cmd_ba), 32'd0);
        do_reset();

        // closed-bank read
        b = now;
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 0, 14'h123, 10'h02A, 0, 1);
            cycle();
        end
        chk("s1_act", 32'(dc(b + 1)), 32'h4);
        chk("s1_act_addr", 32'(d_a[b + 1]), 32'h123);
        chk("s1_rd", 32'(dc(b + 5)), 32'h5);
        chk("s1_rd_addr", 32'(d_a[b + 5]), 32'h02A);
        chk("s1_rr_lo", 32'(d_rr[b + 5]), 32'd0);
        chk("s1_rr_hi", 32'(d_rr[b + 6]), 32'd1);
        do_reset();

        // two row-hit writes
        b = now;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0 || i == 6, 1, 14'h055, (i == 0) ? 10'd1 : 10'd2, 0, 1);
            cycle();
        end
        chk("s2_wr1", 32'(dc(b + 5)), 32'h6);
        chk("s2_gap", 32'(d_v[b + 6]), 32'd0);
        chk("s2_wr2", 32'(dc(b + 7)), 32'h6);
        chk("s2_wr2_addr", 32'(d_a[b + 7]), 32'd2);
        do_reset();

        // row miss after read
        b = now;
        for (int i = 0; i < 24; i++) begin
            drive(i == 0 || i == 6, 0, (i == 0) ? 14'h010 : 14'h020, 10'h3, 0, 1);
            cycle();
        end
        chk("s3_pre_early", 32'(d_v[b + 12]), 32'd0);
        chk("s3_pre", 32'(dc(b + 13)), 32'h7);
        chk("s3_act", 32'(dc(b + 17)), 32'h4);
        chk("s3_act_addr", 32'(d_a[b + 17]), 32'h020);
        chk("s3_rd", 32'(dc(b + 21)), 32'h5);
        do_reset();

        // write recovery holds PRE past tRAS
        b = now;
        for (int i = 0; i < 17; i++) begin
            drive(i == 0 || i == 6, i == 0, (i == 0) ? 14'h010 : 14'h030, 10'h4, 0, 1);
            cycle();
        end
        chk("s4_wr", 32'(dc(b + 5)), 32'h6);
        chk("s4_no_pre13", 32'(d_v[b + 13]), 32'd0);
        chk("s4_pre", 32'(dc(b + 14)), 32'h7);
        do_reset();

        // refresh with a pending miss
        b = now;
        nact = 0;
        for (int i = 0; i < 30; i++) begin
            drive(i == 0 || i == 6, 0, (i == 0) ? 14'h011 : 14'h022, 10'h5,
                  i >= 7 && i <= 25, 1);
            cycle();
        end
        for (int i = 14; i <= 25; i++) if (dc(b + i) == 3'h4) nact++;
        chk("s5_pre", 32'(dc(b + 13)), 32'h7);
        chk("s5_ack_lo", 32'(d_ack[b + 16]), 32'd0);
        chk("s5_ack_hi", 32'(d_ack[b + 17]), 32'd1);
        chk("s5_rr_lo", 32'(d_rr[b + 20]), 32'd0);
        chk("s5_no_act", 32'(nact), 32'd0);
        chk("s5_act", 32'(dc(b + 26)), 32'h4);
        chk("s5_act_addr", 32'(d_a[b + 26]), 32'h022);
        do_reset();

        // arbiter stall on an offered RD
        b = now;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 0, 14'h077, 10'h1F, 0, !(i >= 5 && i <= 7));
            cycle();
        end
        chk("s6_hold_v", 32'(d_v[b + 7]), 32'd1);
        chk("s6_hold_t", 32'(d_t[b + 7]), 32'd1);
        chk("s6_hold_a", 32'(d_a[b + 6]), 32'h01F);
        chk("s6_rd", 32'(dc(b + 8)), 32'h5);

        // reset during the ACT-to-RD wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 0, 14'h0AB, 10'h1, 0, 1);
            cycle();
        end
        chk("s7_open_before", 32'(bank_open), 32'd1);
        do_reset();

        // random traffic
        rf = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) rf = !rf;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  14'($urandom_range(0, 3) * 257), 10'($urandom),
                  rf, $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sal_bank_ctrl.md
# sal_bank_ctrl

Per-bank DRAM command sequencer for the DDR2 controller. It accepts one read/write request at a time from the request scheduler and tracks that bank's open/closed row state. It issues ACT, RD, WR and PRE commands with the bank's DDR2 timing constraints enforced by internal counters. Commands go over a valid/ready handshake to the shared command arbiter that drives the DDR PHY pins (cs_n/ras_n/cas_n/we_n/ba/addr). The block also closes its row on a refresh request and reports when the bank is precharged and idle.

## Interface
- BANK_ID, 0: constant driven on cmd_ba.
- BA_WIDTH, 3: bank address width.
- ADDR_WIDTH, 14: DRAM address bus width, equal to the row width.
- COL_WIDTH, 10: column width, must be ≤ 10.
- T_RCD, 4: minimum cycles from ACT to RD/WR.
- T_RP, 4: minimum cycles from PRE to ACT.
- T_RAS, 12: minimum cycles from ACT to PRE.
- T_RTP, 2: minimum cycles from RD to PRE.
- T_WTP, 9: minimum cycles from WR to PRE (WL + BL/2 + tWR).
- T_CCD, 2: minimum cycles from RD/WR to RD/WR.
- All T_* parameters lie in 1..63. Counters are 6 bits wide.

Ports:
- clk  in  1  controller clock, 2x DRAM command clock not used (1:1).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when it is high together with req_valid.
- req_wr  in  1  1 = write, 0 = read.
- req_row  in  ADDR_WIDTH  row address.
- req_col  in  COL_WIDTH  column address.
- cmd_valid  out  1  command offered to the arbiter.
- cmd_ready  in  1  arbiter issues the command this cycle.
- cmd_type  out  2  0 = ACT, 1 = RD, 2 = WR, 3 = PRE.
- cmd_ba  out  BA_WIDTH  always BANK_ID.
- cmd_addr  out  ADDR_WIDTH  row for ACT; for RD/WR: {0, col}, with bit 10 = 0 (no auto-precharge); for PRE: 0.
- ref_req  in  1  refresh pending; the bank must close.
- ref_ack  out  1  bank is closed and T_RP has elapsed.
- bank_open  out  1  a row is open.
- open_row  out  ADDR_WIDTH  currently open row.

## Operation
- One-entry pending buffer (pend_valid, wr, row, col).
- req_ready = !pend_valid && !ref_req. The request is captured at the accepting edge.
- State CLOSED/OPEN. bank_open = (state == OPEN).
- Counters: rcd_cnt, rp_cnt, ras_cnt, pre_cnt, ccd_cnt.
  - On issue of a command constraining a later command, the counter loads T−1.
  - Each counter decrements by 1 per cycle while nonzero, saturating at 0.
  - The constrained command is eligible only when its counter is 0.
  - pre_cnt loads max(pre_cnt−1, T_RTP−1) on RD and max(pre_cnt−1, T_WTP−1) on WR.
- Command selection, combinational each cycle, in priority order:
  - OPEN, pend_valid, pend_row == open_row, rcd_cnt == 0, ccd_cnt == 0 → RD or WR per pend_wr. On issue: pend_valid clears, ccd_cnt and pre_cnt load.
  - OPEN, (ref_req, or pend_valid with a row miss), ras_cnt == 0, pre_cnt == 0 → PRE. On issue: state becomes CLOSED and rp_cnt loads.
  - CLOSED, pend_valid, !ref_req, rp_cnt == 0 → ACT with pend_row. On issue: state becomes OPEN, open_row = pend_row, rcd_cnt and ras_cnt load.
  - Otherwise cmd_valid = 0.
- A row hit issues its column command before a refresh-forced PRE.
- During refresh a pending request is held and resumes after ref_req falls.
- ref_ack = (state == CLOSED) && rp_cnt == 0.
- cmd_valid and the command fields stay stable until handshake, with one exception: ref_req rising withdraws an offered ACT.
- A command issues only on cmd_valid && cmd_ready.

## Timing
- Reset values: state CLOSED, all counters 0, pend_valid 0, open_row 0, bank_open 0, cmd_valid 0, cmd_type 0, cmd_addr 0, cmd_ba BANK_ID.
- Post-reset, req_ready = !ref_req and ref_ack = 1.
- Request accepted at edge n → its first command is offered in cycle n+1.
- Command issued in cycle n with constraint T → the dependent command is first eligible in cycle n+T.
- Closed-bank read with no stalls: ACT in cycle n+1, RD in cycle n+1+T_RCD.
- req_ready rises in the cycle after the RD/WR handshake.
- A back-to-back request accepted in that cycle gives, for a hit, a column command T_CCD after the previous one.
- cmd_ready low: the command is held and the counters continue to decrement.
- Reset asserted mid-sequence: all state is cleared immediately. Any pending request is dropped. The DRAM-side recovery (PRE-all) is the initializer's responsibility.

## Test plan
- Read, closed bank, T_RCD=4, cmd_ready=1: request accepted at cycle 0 (row 0x123, col 0x2A) → ACT addr 0x123 at cycle 1, RD addr 0x02A at cycle 5, req_ready high at cycle 6.
- Two row-hit writes, T_CCD=2, second request accepted at cycle 6 → WR at cycles 5 and 7; no ACT or PRE in between.
- Row miss after ACT at cycle 1, T_RAS=12, T_RP=4 → PRE at cycle 13, ACT with the new row at cycle 17, column command at cycle 21.
- WR at cycle 5, T_WTP=9, then a miss → PRE no earlier than cycle 14, even though ras_cnt is already 0.
- ref_req raised while OPEN with a pending miss → PRE issues, no ACT while ref_req is high, ref_ack high T_RP cycles after PRE, req_ready low. After ref_req drops: ACT next cycle.
- cmd_ready held low 3 cycles during an offered RD → cmd_valid/type/addr stable, RD issues on the first cycle cmd_ready=1. rst_n pulsed low mid-ACT wait → all outputs return to reset values asynchronously.
